// File: rtl/program_sequencer.sv
// Program sequencer: feeds a host-loaded program to the CPU over Din/run/done.
// Issues one word per instruction, supplies mvi immediates, stops on HALT, end of memory or timeout.
module program_sequencer #(
    parameter int word    = 16,
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [word-1:0] load_data,
    input  logic            start,
    input  logic            cpu_done,
    output logic [word-1:0] din,
    output logic            run,
    output logic            busy,
    output logic            halted,
    output logic            error,
    output logic [AW:0]     pc,
    output logic [15:0]     instr_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;
    localparam logic [AW:0] PC_END  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PC_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_HALT,
        S_ERR
    } state_t;

    state_t          state, state_n;
    logic [AW:0]     pc_n;
    logic [15:0]     count_n;
    logic [TW-1:0]   timer, timer_n;
    logic [word-1:0] mem [DEPTH];
    logic [word-1:0] cur;
    logic [2:0]      op;
    logic            restart;
    logic            complete;

    assign cur     = mem[pc[AW-1:0]];
    assign op      = cur[8:6];
    // A simultaneous load wins over start when idle.
    assign restart = start && !load_en;

    assign run    = (state == S_ISSUE);
    assign busy   = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT);
    assign halted = (state == S_HALT);
    assign error  = (state == S_ERR);
    assign din    = ((state == S_ISSUE) || (state == S_IMM)) ? cur : '0;

    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        count_n  = instr_count;
        timer_n  = timer;
        complete = 1'b0;
        unique case (state)
            S_IDLE, S_HALT, S_ERR: begin
                if (restart) begin
                    state_n = S_ISSUE;
                    pc_n    = '0;
                    count_n = '0;
                end
            end
            S_ISSUE: begin
                if (op == OP_HALT) begin
                    state_n = S_HALT;
                end else if (op == OP_MVI && pc == PC_LAST) begin
                    state_n = S_ERR;
                end else begin
                    pc_n    = pc + 1'b1;
                    timer_n = '0;
                    state_n = (op == OP_MVI) ? S_IMM : S_WAIT;
                end
            end
            S_IMM: begin
                pc_n    = pc + 1'b1;
                timer_n = '0;
                if (cpu_done) begin
                    complete = 1'b1;
                    state_n  = (pc_n == PC_END) ? S_HALT : S_ISSUE;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cpu_done) begin
                    complete = 1'b1;
                    state_n  = (pc == PC_END) ? S_HALT : S_ISSUE;
                end else if (timer == T_LAST) begin
                    state_n = S_ERR;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (complete && instr_count != 16'hFFFF) begin
            count_n = instr_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr_count <= '0;
            timer       <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_count <= count_n;
            timer       <= timer_n;
        end
    end

endmodule
